uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
Serial transmit engine that drains the UART TX byte FIFO and shifts each byte out on the tx line: 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit.
It sits between the FIFO read port (data_out / fifo_empty / rd) and the pad.
It issues one read strobe per byte and flags completion when the FIFO runs dry, which the UART controller uses to clear the FIFO.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2
PARITY_EN, 0, 1 inserts a parity bit between data bit 7 and the stop bit
PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  transmit enable (UART_CON[0] EN)
fifo_data  input  8  FIFO head byte (combinational FIFO data_out)
fifo_empty  input  1  FIFO empty flag
fifo_rd  output  1  FIFO read strobe (drives FIFO rd), one cycle per byte
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress
rddone  output  1  one-cycle pulse: frame finished and FIFO empty
bit_index  output  3  current data bit index (0 outside DATA)

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; clock counter and bit_index clear to 0.
  - Outputs: tx=1, busy=0, rddone=0, fifo_rd=0.
  - Applies mid-frame: the frame is abandoned and tx returns high on the next cycle. No FIFO read occurs in the reset cycle.
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
- Clock counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Each bit is held exactly CLKS_PER_BIT cycles. The counter wraps to 0 on each bit boundary.
- Load condition: load = en & ~fifo_empty & (state==IDLE, or state==STOP on its last count).
- fifo_rd:
  - fifo_rd = load, combinational. The FIFO advances rptr on that same edge.
  - On that edge, fifo_data is captured into an 8-bit shift register, parity is computed (XOR of the 8 bits, inverted if PARITY_ODD), and the state moves to START.
  - fifo_rd is never asserted while fifo_empty=1 or rst=1.
- Latency: tx falls on the cycle after the edge where fifo_rd=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_index=0.
- DATA:
  - tx = shift register bit 0. Shift right at each bit boundary.
  - bit_index increments 0..7. After bit 7 completes, go to PARITY (if PARITY_EN) else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last count:
  - If load: back-to-back frame (the next START follows immediately with no idle bit).
  - Else: go to IDLE. Pulse rddone for one cycle (registered, same cycle as the IDLE entry) if fifo_empty=1 at that edge.
- Frame length: (10 + PARITY_EN) * CLKS_PER_BIT cycles. busy=1 for exactly that many cycles per frame, and stays continuously high across back-to-back frames.
- en handling:
  - en is sampled only at load points.
  - Deasserting en mid-frame completes the current frame, then the engine idles. No rddone pulse occurs if the FIFO is still non-empty.
- No transmit is ever started while fifo_empty=1. In IDLE, tx=1 constantly.
- rddone never pulses outside a STOP->IDLE transition.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, single byte 0xA5, en=1 -> fifo_rd one cycle. tx: 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4. busy high 40 cycles. rddone pulses once on return to IDLE.
2. Three bytes 0x00, 0xFF, 0x55 queued, en=1 -> three single-cycle fifo_rd pulses. tx falling start edges exactly 40 cycles apart, no idle gap. busy continuous for 120 cycles. One rddone, after the third frame only.
3. PARITY_EN=1, byte 0x07 -> parity bit 1 (even); with PARITY_ODD=1 -> parity bit 0. Frame is 44 cycles in both cases.
4. Two bytes queued, en dropped during DATA of frame 1 -> frame 1 completes intact. No second fifo_rd, no rddone. tx stays 1 and fifo_empty stays 0.
5. rst asserted for 1 cycle during DATA bit_index=3 -> next cycle tx=1, busy=0, bit_index=0, no fifo_rd in the reset cycle. After release with en=1 and FIFO non-empty, a fresh full frame starts with a single fifo_rd.
6. en=1, fifo_empty=1 for 100 cycles -> fifo_rd never asserted, tx=1, busy=0, rddone=0.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: drains the TX FIFO one byte per frame and shifts it out
// as 1 start bit, 8 data bits LSB first, an optional parity bit and 1 stop bit.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       rddone,
  output logic [2:0] bit_index
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          last_cnt;
  logic          load;

  assign last_cnt = (cnt == CNT_LAST);

  // A new byte is taken either from idle or straight out of the last stop
  // cycle, which is what makes back-to-back frames gapless.
  assign load    = en & ~fifo_empty & ~rst &
                   ((state == S_IDLE) | ((state == S_STOP) & last_cnt));
  assign fifo_rd = load;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_index <= '0;
      tx        <= 1'b1;
      rddone    <= 1'b0;
    end else begin
      rddone <= 1'b0;
      if (state != S_IDLE) begin
        cnt <= last_cnt ? '0 : cnt + CW'(1);
      end
      if (load) begin
        shreg   <= fifo_data;
        par_bit <= (^fifo_data) ^ (PARITY_ODD != 0);
        state   <= S_START;
        cnt     <= '0;
        tx      <= 1'b0;
      end else if (last_cnt) begin
        case (state)
          S_START: begin
            state     <= S_DATA;
            bit_index <= '0;
            tx        <= shreg[0];
          end
          S_DATA: begin
            shreg <= {1'b0, shreg[7:1]};
            if (bit_index == 3'd7) begin
              bit_index <= '0;
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_index <= bit_index + 3'd1;
              tx        <= shreg[1];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
          // Stop bit ended with nothing to load: report a drained FIFO.
          S_STOP: begin
            state  <= S_IDLE;
            tx     <= 1'b1;
            rddone <= fifo_empty;
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
